// File: rtl/frame_buf_ctrl.sv
// Double-buffered frame-buffer write scheduler: aligns pixel writes to camera frames,
// writes into the bank not on display, and swaps banks on display vblank once a frame is complete.
module frame_buf_ctrl #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_capture_en,
   input  logic              i_snap,
   input  logic              i_frame_start,
   input  logic              i_vblank,
   input  logic [7:0]        i_data,
   input  logic              i_data_valid,
   output logic              o_data_ready,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [7:0]        o_wr_data,
   output logic              o_wr_bank,
   output logic              o_rd_bank,
   output logic              o_frame_done,
   output logic [7:0]        o_frame_cnt,
   output logic [15:0]       o_drop_cnt,
   output logic              o_err_short
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_WRITE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_snap_q;
   logic              r_single;
   logic              r_pending;
   logic              r_rd_bank;
   logic [ADDR_W-1:0] r_addr;
   logic              r_data_ready;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;
   logic              r_frame_done;
   logic [7:0]        r_frame_cnt;
   logic [15:0]       r_drop_cnt;
   logic              r_err_short;

   logic w_accept;
   logic w_in_write;
   logic w_last;
   logic w_open;
   logic w_armed;

   assign w_accept   = i_data_valid & r_data_ready;
   assign w_in_write = (r_state == S_WRITE);
   assign w_last     = w_in_write & w_accept & (r_addr == LAST_ADDR);
   // A pending (unswapped) frame blocks new frames so writes never hit the displayed bank.
   assign w_open     = (r_state == S_WAIT_SOF) & i_frame_start & ~r_pending;
   assign w_armed    = i_capture_en | r_snap_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_armed) w_state_nxt = S_WAIT_SOF;
         end
         S_WAIT_SOF: begin
            if (w_open)                             w_state_nxt = S_WRITE;
            else if (!i_capture_en && !r_single)    w_state_nxt = S_IDLE;
         end
         S_WRITE: begin
            if (w_last) w_state_nxt = (r_single || !i_capture_en) ? S_IDLE : S_WAIT_SOF;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_snap_q     <= 1'b0;
         r_single     <= 1'b0;
         r_pending    <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_addr       <= '0;
         r_data_ready <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
         r_drop_cnt   <= '0;
         r_err_short  <= 1'b0;
      end else begin
         r_data_ready <= 1'b1;
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;

         if (r_state == S_IDLE) begin
            if (w_armed) begin
               r_single <= r_snap_q | i_snap;
               r_snap_q <= 1'b0;
            end else begin
               r_snap_q <= i_snap;
            end
         end

         if (w_accept && !w_in_write && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;

         if (w_open) r_addr <= '0;

         if (i_vblank && r_pending) begin
            r_rd_bank <= ~r_rd_bank;
            r_pending <= 1'b0;
         end

         if (w_in_write) begin
            if (w_accept) begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_addr;
               r_wr_data <= i_data;
               r_addr    <= r_addr + ADDR_W'(1);
            end
            // Completion wins over a restart landing on the final beat.
            if (w_last) begin
               r_pending    <= 1'b1;
               r_frame_done <= 1'b1;
               r_frame_cnt  <= r_frame_cnt + 8'd1;
               r_single     <= 1'b0;
            end else if (i_frame_start) begin
               r_err_short <= 1'b1;
               r_addr      <= '0;
            end
         end
      end
   end

   assign o_data_ready = r_data_ready;
   assign o_wr_en      = r_wr_en;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = r_wr_data;
   assign o_rd_bank    = r_rd_bank;
   assign o_wr_bank    = ~r_rd_bank;
   assign o_frame_done = r_frame_done;
   assign o_frame_cnt  = r_frame_cnt;
   assign o_drop_cnt   = r_drop_cnt;
   assign o_err_short  = r_err_short;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Scoreboard bench for frame_buf_ctrl with a 4x2 frame: stimulus queues expected writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_frame_buf_ctrl;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 2;
   localparam int ADDR_W = 19;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      logic              bank;
      logic              done;
   } wr_t;

   logic              clk = 1'b0;
   logic              i_rst, i_capture_en, i_snap, i_frame_start, i_vblank;
   logic [7:0]        i_data;
   logic              i_data_valid;
   logic              o_data_ready, o_wr_en, o_wr_bank, o_rd_bank, o_frame_done, o_err_short;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [7:0]        o_wr_data, o_frame_cnt;
   logic [15:0]       o_drop_cnt;

   int  n_checks = 0;
   int  n_err    = 0;
   wr_t exp_q[$];
   wr_t m_exp, m_act;

   frame_buf_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_capture_en(i_capture_en), .i_snap(i_snap),
      .i_frame_start(i_frame_start), .i_vblank(i_vblank), .i_data(i_data),
      .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .o_wr_en(o_wr_en),
      .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_bank(o_wr_bank),
      .o_rd_bank(o_rd_bank), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
      .o_drop_cnt(o_drop_cnt), .o_err_short(o_err_short)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // One cycle with optional frame-start, vblank and pixel beat.
   task automatic cyc(input logic sof, input logic vb, input logic v, input logic [7:0] d);
      i_frame_start = sof;
      i_vblank      = vb;
      i_data_valid  = v;
      i_data        = d;
      tick();
      i_frame_start = 1'b0;
      i_vblank      = 1'b0;
      i_data_valid  = 1'b0;
   endtask

   task automatic expect_wr(input int a, input logic [7:0] d, input logic b, input logic dn);
      wr_t e;
      e.addr = ADDR_W'(a);
      e.data = d;
      e.bank = b;
      e.done = dn;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!i_rst) begin
         if (o_wr_en) begin
            n_checks++;
            m_act = '{addr: o_wr_addr, data: o_wr_data, bank: o_wr_bank, done: o_frame_done};
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL wr_unexpected: addr=%0d data=0x%0h bank=%0d done=%0d, none expected",
                        o_wr_addr, o_wr_data, o_wr_bank, o_frame_done);
            end else begin
               m_exp = exp_q.pop_front();
               if (m_act !== m_exp) begin
                  n_err++;
                  $display("FAIL wr: got addr=%0d data=0x%0h bank=%0d done=%0d expected addr=%0d data=0x%0h bank=%0d done=%0d",
                           m_act.addr, m_act.data, m_act.bank, m_act.done,
                           m_exp.addr, m_exp.data, m_exp.bank, m_exp.done);
               end
            end
         end else if (o_frame_done) begin
            n_checks++;
            n_err++;
            $display("FAIL done_no_wr: got frame_done=1 wr_en=0 expected frame_done=0");
         end
      end
   end

   initial begin
      i_rst = 1'b1; i_capture_en = 1'b0; i_snap = 1'b0; i_frame_start = 1'b0;
      i_vblank = 1'b0; i_data = 8'h00; i_data_valid = 1'b0;
      idle(2);
      check("rst_ready",    32'(o_data_ready), 32'd0);
      check("rst_wr_en",    32'(o_wr_en),      32'd0);
      check("rst_wr_addr",  32'(o_wr_addr),    32'd0);
      check("rst_rd_bank",  32'(o_rd_bank),    32'd0);
      check("rst_wr_bank",  32'(o_wr_bank),    32'd1);
      check("rst_frame_cnt",32'(o_frame_cnt),  32'd0);
      check("rst_drop_cnt", 32'(o_drop_cnt),   32'd0);
      check("rst_err",      32'(o_err_short),  32'd0);
      i_rst = 1'b0;
      tick();
      check("ready_rise", 32'(o_data_ready), 32'd1);

      // Idle: beats with capture off are dropped
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i));
      check("idle_drop", 32'(o_drop_cnt), 32'd3);
      check("idle_rd",   32'(o_rd_bank),  32'd0);
      check("idle_wr",   32'(o_wr_bank),  32'd1);

      // Continuous capture, first frame into bank 1
      i_capture_en = 1'b1;
      idle(2);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         expect_wr(i, 8'h10 + 8'(i), 1'b1, i == 7);
         cyc(1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
      end
      check("f1_cnt",     32'(o_frame_cnt), 32'd1);
      check("f1_rd_hold", 32'(o_rd_bank),   32'd0);

      // Frame start while pending: whole frame skipped
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 8'h70 + 8'(i));
      check("skip_drop", 32'(o_drop_cnt),  32'd11);
      check("skip_cnt",  32'(o_frame_cnt), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check("swap1_rd", 32'(o_rd_bank), 32'd1);
      check("swap1_wr", 32'(o_wr_bank), 32'd0);

      // Short frame into bank 0; beat on the opening frame start is dropped
      cyc(1'b1, 1'b0, 1'b1, 8'hEE);
      check("open_drop", 32'(o_drop_cnt), 32'd12);
      for (int i = 0; i < 4; i++) begin
         expect_wr(i, 8'h30 + 8'(i), 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b1, 8'h30 + 8'(i));
      end
      expect_wr(4, 8'h34, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 8'h34);
      check("short_err", 32'(o_err_short), 32'd1);
      for (int i = 0; i < 8; i++) begin
         expect_wr(i, 8'h40 + 8'(i), 1'b0, i == 7);
         cyc(1'b0, 1'b0, 1'b1, 8'h40 + 8'(i));
      end
      check("short_cnt",    32'(o_frame_cnt), 32'd2);
      check("short_sticky", 32'(o_err_short), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check("swap2_rd", 32'(o_rd_bank), 32'd0);

      // Completion and vblank in the same cycle: swap deferred
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         expect_wr(i, 8'h50 + 8'(i), 1'b1, i == 7);
         cyc(1'b0, i == 7, 1'b1, 8'h50 + 8'(i));
      end
      check("same_cnt",  32'(o_frame_cnt), 32'd3);
      check("same_rd",   32'(o_rd_bank),   32'd0);
      idle(1);
      check("same_rd_2", 32'(o_rd_bank),   32'd0);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check("swap3_rd", 32'(o_rd_bank), 32'd1);
      check("swap3_wr", 32'(o_wr_bank), 32'd0);

      // Snap: one frame written, the next ignored
      i_capture_en = 1'b0;
      idle(2);
      i_snap = 1'b1;
      tick();
      i_snap = 1'b0;
      idle(2);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         expect_wr(i, 8'h60 + 8'(i), 1'b0, i == 7);
         cyc(1'b0, 1'b0, 1'b1, 8'h60 + 8'(i));
      end
      check("snap_cnt", 32'(o_frame_cnt), 32'd4);
      idle(1);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 8'h80 + 8'(i));
      check("snap_cnt_hold", 32'(o_frame_cnt), 32'd4);
      check("snap_drop",     32'(o_drop_cnt),  32'd20);

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
      idle(1);
      check("queue_drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/frame_buf_ctrl.md
# frame_buf_ctrl

Double-buffered frame-buffer write scheduler between the sobel-filtered pixel stream and the frame-buffer BRAM write port. It aligns writes to camera frame boundaries and generates sequential write addresses into the bank not being displayed. The displayed (read) bank swaps only during display vertical blank, and only after a complete frame has been written. It never back-pressures the pixel stream: beats outside an active frame window are dropped and counted.

## Interface
- IMG_W, 640, pixels per row
- IMG_H, 480, rows per frame
- ADDR_W, 19, BRAM write address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_capture_en  in  1  level; continuous capture
- i_snap  in  1  one-cycle pulse; single-frame capture request
- i_frame_start  in  1  one-cycle pulse at camera start-of-frame, already synchronized to i_clk
- i_vblank  in  1  one-cycle pulse at display vertical-blank start, already synchronized to i_clk
- i_data  in  8  sobel pixel byte
- i_data_valid  in  1  pixel valid
- o_data_ready  out  1  pixel ready
- o_wr_en  out  1  BRAM write strobe
- o_wr_addr  out  ADDR_W  BRAM write address within the bank
- o_wr_data  out  8  BRAM write data
- o_wr_bank  out  1  bank being written; always ~o_rd_bank
- o_rd_bank  out  1  bank selected for display read
- o_frame_done  out  1  one-cycle pulse when the last pixel of a frame is written
- o_frame_cnt  out  8  completed frames; wraps at 255 to 0
- o_drop_cnt  out  16  dropped beats; saturates at 0xFFFF
- o_err_short  out  1  sticky; set when a frame restarts before it is complete

## Operation
- States: IDLE, WAIT_SOF, WRITE.
- Arm condition: i_capture_en=1, or a latched i_snap. i_snap is latched only in IDLE; it is ignored in the other states.
- IDLE:
  - Armed -> WAIT_SOF. A latched snap sets internal `single`=1.
- WAIT_SOF:
  - On i_frame_start with pending=0 -> WRITE, addr=0.
  - On i_frame_start with pending=1 -> frame skipped; stay in WAIT_SOF.
  - i_capture_en=0 and single=0 -> IDLE.
- WRITE:
  - Each accepted beat (valid & ready) is written at addr, then addr increments.
  - Beat at addr = IMG_W*IMG_H-1: pending<=1, o_frame_done pulse, o_frame_cnt++.
    - Then: if single=1 or i_capture_en=0 -> IDLE, single<=0. Otherwise -> WAIT_SOF.
  - i_frame_start in WRITE before completion: o_err_short<=1, addr<=0, same bank, stay in WRITE. A beat accepted in the same cycle is written at the old address; the next beat is written at addr 0.
  - Deasserting i_capture_en mid-frame does not abort; the frame completes.
- Dropping:
  - o_data_ready=1 in every state after reset.
  - Beats accepted outside WRITE are not written, and o_drop_cnt increments.
- Swap:
  - On i_vblank with registered pending=1: o_rd_bank<=~o_rd_bank, pending<=0.
  - i_vblank with pending=0: no effect.
  - Completion and i_vblank in the same cycle: the swap uses the pre-update pending (0), so it waits for the next i_vblank.
- Invariant: writes never target o_rd_bank. No frame starts while pending=1.

## Timing
- Reset values:
  - State IDLE; single=0, pending=0.
  - o_rd_bank=0, o_wr_bank=1.
  - o_data_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0.
  - o_frame_done=0, o_frame_cnt=0, o_drop_cnt=0, o_err_short=0.
- o_data_ready rises 1 cycle after i_rst deasserts.
- Write latency is 1 cycle. A beat accepted at cycle N produces o_wr_en=1 with its o_wr_addr and o_wr_data at N+1.
- o_frame_done is asserted in the same cycle as the o_wr_en of the last pixel.
- o_wr_bank is combinational from o_rd_bank. o_rd_bank changes the cycle after the i_vblank that performs the swap.
- i_frame_start is acted on 1 cycle after it arrives (registered state transition). A beat accepted in the same cycle as the i_frame_start that opens a frame is dropped.
- i_rst mid-frame: everything returns to reset values next cycle. No further writes are issued. Bank contents are not cleared.

## Test plan
Parameters: IMG_W=4, IMG_H=2 (8 pixels).
- Reset/idle: after reset, 3 beats with i_capture_en=0 -> o_wr_en never 1, o_drop_cnt=3, o_rd_bank=0, o_wr_bank=1.
- Continuous capture, single frame:
  - Stimulus: i_capture_en=1, i_frame_start, then 8 beats 0x10..0x17.
  - Writes: addr 0..7, data 0x10..0x17, bank 1.
  - o_frame_done on addr 7, o_frame_cnt=1.
  - Next i_vblank -> o_rd_bank=1, o_wr_bank=0.
- Skip while pending: frame completes, then i_frame_start arrives before i_vblank -> no writes for that frame, and its 8 beats raise o_drop_cnt by 8. After i_vblank, the next i_frame_start writes bank 0.
- Short frame: i_frame_start after 5 beats -> o_err_short=1, then 8 beats written at addr 0..7 in the same bank, with one o_frame_done.
- Snap: i_capture_en=0, i_snap pulse, two frames offered -> only the first is written (o_frame_cnt=1), state returns to IDLE, and all 8 beats of the second frame are dropped.
- Same-cycle completion and i_vblank: o_rd_bank unchanged that cycle; it toggles on the following i_vblank.
